mysystem_nios2_oci_dct_ctrl: RTL

//  Trace-atom packer/scheduler feeding the OCI debug-trace path. Packs 2-bit atoms

---
 rtl/mysystem_nios2_oci_dct_ctrl_if.sv | 32 +++
 rtl/mysystem_nios2_oci_dct_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mysystem_nios2_oci_dct_ctrl_if.sv
// Trace-atom producer and packed-word consumer signals of the DCT packer.
// master = atom source / trace storage side, slave = packer.
interface mysystem_nios2_oci_dct_ctrl_if #(
    parameter int ATOM_W    = 2,
    parameter int MAX_ATOMS = 15,
    parameter int CNT_W     = 4
);
    localparam int BUF_W = ATOM_W * MAX_ATOMS;

    logic              trace_en;
    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [BUF_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              overflow;
    logic              overflow_clr;

    modport master (
        output trace_en, atom_valid, atom_data, flush, out_ready, overflow_clr,
        input  out_valid, out_data, out_count, dct_buffer, dct_count, overflow
    );

    modport slave (
        input  trace_en, atom_valid, atom_data, flush, out_ready, overflow_clr,
        output out_valid, out_data, out_count, dct_buffer, dct_count, overflow
    );
endinterface

// File: rtl/mysystem_nios2_oci_dct_ctrl.sv
// Packs 2-bit trace atoms into 30-bit words; a completed or flushed word is out_valid the next cycle.
// One-entry output register with valid/ready; while it is held, accumulation continues up to 15 atoms, then atoms drop.
module mysystem_nios2_oci_dct_ctrl #(
    parameter int ATOM_W    = 2,
    parameter int MAX_ATOMS = 15,
    parameter int CNT_W     = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    mysystem_nios2_oci_dct_ctrl_if.slave    bus
);
    localparam int BUF_W = ATOM_W * MAX_ATOMS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_ATOMS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  dct_buffer_q;
    logic [CNT_W-1:0]  dct_count_q;
    logic              flush_pend_q;
    logic              overflow_q;
    logic              out_valid_q;
    logic [BUF_W-1:0]  out_data_q;
    logic [CNT_W-1:0]  out_count_q;

    logic              atom_req;
    logic              accept;
    logic              drop;
    logic              out_free;
    logic              xfer;
    logic              do_xfer;
    logic [BUF_W-1:0]  merged_buf;
    logic [CNT_W-1:0]  merged_cnt;

    assign atom_req = bus.trace_en && bus.atom_valid;
    assign accept   = atom_req && (dct_count_q < FULL_CNT);
    assign drop     = atom_req && (dct_count_q == FULL_CNT);
    assign out_free = !out_valid_q || bus.out_ready;

    // Same-cycle atom is folded in before deciding on a transfer, so an atom
    // arriving with flush (or completing the word) lands in the emitted word.
    always_comb begin
        merged_buf = dct_buffer_q;
        merged_cnt = dct_count_q;
        if (accept) begin
            for (int i = 0; i < MAX_ATOMS; i++) begin
                if (dct_count_q == CNT_W'(i)) begin
                    merged_buf[i*ATOM_W +: ATOM_W] = bus.atom_data;
                end
            end
            merged_cnt = dct_count_q + CNT_W'(1);
        end
    end

    assign xfer    = (merged_cnt == FULL_CNT) ||
                     ((bus.flush || flush_pend_q) && (merged_cnt != '0));
    assign do_xfer = xfer && out_free;

    // Packing state is a view of count/flush_pend; it tracks where the word is.
    always_comb begin
        state_d = state_q;
        if (do_xfer) begin
            state_d = EMPTY;
        end else if (xfer) begin
            state_d = WAIT;
        end else if (merged_cnt != '0) begin
            state_d = FILL;
        end else begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer_q <= '0;
            dct_count_q  <= '0;
            flush_pend_q <= 1'b0;
        end else if (do_xfer) begin
            dct_buffer_q <= '0;
            dct_count_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            dct_buffer_q <= merged_buf;
            dct_count_q  <= merged_cnt;
            // A flush that cannot be served now is remembered until the output frees.
            if (bus.flush && (merged_cnt != '0)) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else if (do_xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= merged_buf;
            out_count_q <= merged_cnt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Set beats clear when a drop and overflow_clr coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_count  = out_count_q;
    assign bus.dct_buffer = dct_buffer_q;
    assign bus.dct_count  = dct_count_q;
    assign bus.overflow   = overflow_q;
endmodule
